// File: rtl/pkt_writer_pkg.sv
// Shared types and constants for the packet ingress writer.
package pkt_writer_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   localparam logic [3:0]        MEM_WIDTH_WORD = 4'd4;
   localparam logic [ADDR_W-1:0] PKT_LEN_OFF    = 32'd4;

   typedef enum logic [2:0] {
      PW_IDLE,
      PW_RECV,
      PW_FLUSH,
      PW_HDR,
      PW_START,
      PW_WAIT
   } pw_state_e;

endpackage

// File: rtl/pkt_writer_byte_packer.sv
// Packs bytes big-endian into a 32-bit word; flush emits a partial word with
// zero-padded low bytes.
module pkt_writer_byte_packer
   import pkt_writer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic              flush_i,
   input  logic [7:0]        byte_i,
   output logic              word_valid_o,
   output logic [DATA_W-1:0] word_o
);

   logic [1:0]        idx_q, idx_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] merged;

   always_comb begin
      merged = shift_q;
      case (idx_q)
         2'd0:    merged[31:24] = byte_i;
         2'd1:    merged[23:16] = byte_i;
         2'd2:    merged[15:8]  = byte_i;
         default: merged[7:0]   = byte_i;
      endcase

      // A flush without a byte only writes if a partial word is pending
      if (push_i) word_valid_o = (idx_q == 2'd3) || flush_i;
      else        word_valid_o = flush_i && (idx_q != 2'd0);
      word_o = push_i ? merged : shift_q;

      idx_d   = idx_q;
      shift_d = shift_q;
      if (word_valid_o) begin
         idx_d   = 2'd0;
         shift_d = '0;
      end else if (push_i) begin
         idx_d   = idx_q + 2'd1;
         shift_d = merged;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         idx_q   <= 2'd0;
         shift_q <= '0;
      end else begin
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

endmodule

// File: rtl/pkt_writer.sv
// Packet ingress writer: stores a byte stream as words at BASE_ADDR+4, then the
// length at BASE_ADDR, then starts proc. Optional limit: PKT_WRITER_LEN_CHECK_EN.
module pkt_writer
   import pkt_writer_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
   parameter int                MAX_PKT_BYTES = 1536
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid_i,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_last_i,
   output logic              rx_ready_o,
   output logic              mem_ce_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_width_o,
   output logic [DATA_W-1:0] mem_data_o,
   output logic [ADDR_W-1:0] pkt_addr_o,
   output logic              proc_start_o,
   input  logic              proc_ready_i,
   output logic [15:0]       pkt_len_o,
   output logic              err_oversize_o
);

   pw_state_e         state_q, state_d;
   logic [15:0]       cnt_q, cnt_d, len_q, len_d;
   logic              rdy_q, rdy_d, prev_rdy_q;
   logic              ce_q, ce_d, start_q, start_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              fire, push, word_valid;
   logic [DATA_W-1:0] word;

   assign fire = rx_valid_i && rdy_q;

`ifdef PKT_WRITER_LEN_CHECK_EN
   localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_BYTES);
   logic over_q, over_d, err_q, err_d;
   // Bytes past the limit are consumed but never reach the packer
   assign push           = fire && (cnt_q < MAX_LEN);
   assign err_oversize_o = err_q;
`else
   assign push           = fire;
   assign err_oversize_o = 1'b0;
`endif

   pkt_writer_byte_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .push_i       (push),
      .flush_i      (fire && rx_last_i),
      .byte_i       (rx_data_i),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      ce_d    = 1'b0;
      addr_d  = '0;
      data_d  = '0;
      start_d = 1'b0;
`ifdef PKT_WRITER_LEN_CHECK_EN
      over_d  = over_q;
      err_d   = 1'b0;
`endif
      // cnt_q is still the index of the byte completing this word
      if (word_valid) begin
         ce_d   = 1'b1;
         addr_d = BASE_ADDR + PKT_LEN_OFF + {16'd0, cnt_q[15:2], 2'b00};
         data_d = word;
      end
      case (state_q)
         PW_IDLE, PW_RECV: begin
            if (fire) begin
`ifdef PKT_WRITER_LEN_CHECK_EN
               if (cnt_q < MAX_LEN) cnt_d = cnt_q + 16'd1;
               else                 over_d = 1'b1;
`else
               cnt_d = cnt_q + 16'd1;
`endif
               state_d = rx_last_i ? PW_FLUSH : PW_RECV;
            end
         end
         PW_FLUSH: begin
            ce_d    = 1'b1;
            addr_d  = BASE_ADDR;
            data_d  = {16'd0, cnt_q};
            state_d = PW_HDR;
         end
         PW_HDR: begin
            len_d   = cnt_q;
            start_d = 1'b1;
`ifdef PKT_WRITER_LEN_CHECK_EN
            err_d   = over_q;
`endif
            state_d = PW_START;
         end
         PW_START: state_d = PW_WAIT;
         PW_WAIT: begin
            if (proc_ready_i && !prev_rdy_q) begin
               state_d = PW_IDLE;
               cnt_d   = '0;
`ifdef PKT_WRITER_LEN_CHECK_EN
               over_d  = 1'b0;
`endif
            end
         end
         default: state_d = PW_IDLE;
      endcase
      rdy_d = (state_d == PW_IDLE) || (state_d == PW_RECV);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= PW_IDLE;
         cnt_q      <= '0;
         len_q      <= '0;
         rdy_q      <= 1'b0;
         prev_rdy_q <= 1'b0;
         ce_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         start_q    <= 1'b0;
`ifdef PKT_WRITER_LEN_CHECK_EN
         over_q     <= 1'b0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         rdy_q      <= rdy_d;
         prev_rdy_q <= proc_ready_i;
         ce_q       <= ce_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         start_q    <= start_d;
`ifdef PKT_WRITER_LEN_CHECK_EN
         over_q     <= over_d;
         err_q      <= err_d;
`endif
      end
   end

   assign rx_ready_o   = rdy_q;
   assign mem_ce_o     = ce_q;
   assign mem_we_o     = ce_q;
   assign mem_addr_o   = addr_q;
   assign mem_width_o  = ce_q ? MEM_WIDTH_WORD : 4'd0;
   assign mem_data_o   = data_q;
   assign pkt_addr_o   = BASE_ADDR + PKT_LEN_OFF;
   assign proc_start_o = start_q;
   assign pkt_len_o    = len_q;

endmodule

// File: tb/tb_pkt_writer.sv
// Randomised and directed packets against a queue-based packet model; a monitor
// compares every memory write and start pulse against the expected queues.
module tb_pkt_writer;

   localparam logic [31:0] BASE = 32'h0;
`ifdef PKT_WRITER_LEN_CHECK_EN
   localparam int MAXB = 8;
`else
   localparam int MAXB = 1536;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rx_valid_i = 1'b0;
   logic [7:0]  rx_data_i = 8'h00;
   logic        rx_last_i = 1'b0;
   logic        rx_ready_o;
   logic        mem_ce_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_data_o, pkt_addr_o;
   logic [3:0]  mem_width_o;
   logic        proc_start_o;
   logic        proc_ready_i = 1'b0;
   logic [15:0] pkt_len_o;
   logic        err_oversize_o;

   pkt_writer #(.BASE_ADDR(BASE), .MAX_PKT_BYTES(MAXB)) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_valid_i     (rx_valid_i),
      .rx_data_i      (rx_data_i),
      .rx_last_i      (rx_last_i),
      .rx_ready_o     (rx_ready_o),
      .mem_ce_o       (mem_ce_o),
      .mem_we_o       (mem_we_o),
      .mem_addr_o     (mem_addr_o),
      .mem_width_o    (mem_width_o),
      .mem_data_o     (mem_data_o),
      .pkt_addr_o     (pkt_addr_o),
      .proc_start_o   (proc_start_o),
      .proc_ready_i   (proc_ready_i),
      .pkt_len_o      (pkt_len_o),
      .err_oversize_o (err_oversize_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   // entry = {kind, addr, data}; kind 0 data, 1 final data write, 2 length word
   logic [65:0] exp_q[$];
   int          exp_len_q[$];
   bit          exp_err_q[$];
   int          last_acc_cyc = 0;
   int          proc_delay = 3;
   int          n_vec = 0;
   int          n_err = 0;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic void fail(input string name, input string msg);
      n_vec++;
      n_err++;
      $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
   endfunction

   // ---------------- reference model ----------------
   task automatic model_pkt(input logic [7:0] pkt[$]);
      int len, nwr, rep, words;
      bit err;
      logic [31:0] w;
      logic [1:0]  kind;
      len = pkt.size();
`ifdef PKT_WRITER_LEN_CHECK_EN
      nwr = (len > MAXB) ? MAXB : len;
      rep = nwr;
      err = (len > MAXB);
`else
      nwr = len;
      rep = len % 65536;
      err = 1'b0;
`endif
      words = (nwr + 3) / 4;
      for (int i = 0; i < words; i++) begin
         w = '0;
         for (int b = 0; b < 4; b++)
            if (4 * i + b < nwr) w = w | (32'(pkt[4 * i + b]) << (24 - 8 * b));
         kind = ((i == words - 1) && (nwr == len || nwr % 4 != 0)) ? 2'd1 : 2'd0;
         exp_q.push_back({kind, BASE + 32'(4 + 4 * i), w});
      end
      exp_q.push_back({2'd2, BASE, 32'(rep)});
      exp_len_q.push_back(rep);
      exp_err_q.push_back(err);
   endtask

   // ---------------- driver ----------------
   task automatic send_pkt(input logic [7:0] pkt[$], input int gap_max, input bit abort);
      int w;
      for (int i = 0; i < pkt.size(); i++) begin
         repeat ($urandom_range(gap_max, 0)) begin
            @(posedge clk);
            #1;
         end
         rx_valid_i = 1'b1;
         rx_data_i  = pkt[i];
         rx_last_i  = !abort && (i == pkt.size() - 1);
         w = 0;
         @(negedge clk);
         while (!rx_ready_o && w < 400) begin
            @(negedge clk);
            w++;
         end
         if (!rx_ready_o) begin
            fail("rx_ready_timeout", "byte never accepted");
            rx_valid_i = 1'b0;
            rx_last_i  = 1'b0;
            return;
         end
         if (rx_last_i) last_acc_cyc = cyc;
         @(posedge clk);
         #1;
         rx_valid_i = 1'b0;
         rx_last_i  = 1'b0;
      end
   endtask

   task automatic wait_done();
      int w = 0;
      while ((exp_q.size() != 0 || exp_len_q.size() != 0 || rx_ready_o !== 1'b1) && w < 1000) begin
         @(negedge clk);
         w++;
      end
      if (w >= 1000) fail("done_timeout", "packet did not complete");
      @(posedge clk);
      #1;
   endtask

   task automatic reset_checks();
      check("rst_mem_ce", mem_ce_o, 0);
      check("rst_rx_ready", rx_ready_o, 0);
      check("rst_start", proc_start_o, 0);
      check("rst_pkt_len", pkt_len_o, 0);
      check("rst_err", err_oversize_o, 0);
      check("rst_width", mem_width_o, 0);
      check("rst_pkt_addr", pkt_addr_o, BASE + 32'd4);
   endtask

   // ---------------- monitor ----------------
   logic [65:0] mon_e;
   always @(negedge clk) begin
      if (rst) begin
         if (mem_ce_o) begin
            if (exp_q.size() == 0) begin
               fail("unexpected_write", $sformatf("addr 0x%0h data 0x%0h", mem_addr_o, mem_data_o));
            end else begin
               mon_e = exp_q.pop_front();
               check("wr_addr", mem_addr_o, mon_e[63:32]);
               check("wr_data", mem_data_o, mon_e[31:0]);
               check("wr_we_width", {mem_we_o, mem_width_o}, {1'b1, 4'd4});
               if (mon_e[65:64] == 2'd1) check("data_latency", cyc - last_acc_cyc, 1);
               if (mon_e[65:64] == 2'd2) check("hdr_latency", cyc - last_acc_cyc, 2);
            end
         end
         if (proc_start_o) begin
            if (exp_len_q.size() == 0) begin
               fail("unexpected_start", "start pulse with no packet pending");
            end else begin
               check("pkt_len", pkt_len_o, exp_len_q.pop_front());
               check("err_oversize", err_oversize_o, exp_err_q.pop_front());
               check("start_latency", cyc - last_acc_cyc, 3);
               check("pkt_addr", pkt_addr_o, BASE + 32'd4);
            end
         end else begin
            check("err_idle", err_oversize_o, 0);
         end
      end
   end

   // ---------------- proc responder ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (rst && proc_start_o) begin
            for (int k = 0; k < proc_delay; k++) begin
               @(negedge clk);
               check("rx_ready_in_wait", rx_ready_o, 0);
            end
            proc_ready_i = 1'b1;
            @(negedge clk);
            proc_ready_i = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] p[$];
   logic [7:0] q2[$];

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_checks();
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 14 bytes 0x00..0x0D
      p = {};
      for (int i = 0; i < 14; i++) p.push_back(8'(i));
      model_pkt(p);
      send_pkt(p, 0, 1'b0);
      wait_done();

      // single byte
      p = {8'hAB};
      model_pkt(p);
      send_pkt(p, 1, 1'b0);
      wait_done();

      // exact multiple of 4
      p = {};
      for (int i = 0; i < 8; i++) p.push_back(8'(8'h10 + i));
      model_pkt(p);
      send_pkt(p, 0, 1'b0);
      wait_done();

      // back-to-back, proc held off 20 cycles
      proc_delay = 20;
      p = {};
      q2 = {};
      for (int i = 0; i < 5; i++) p.push_back(8'($urandom_range(255, 0)));
      for (int i = 0; i < 3; i++) q2.push_back(8'($urandom_range(255, 0)));
      model_pkt(p);
      send_pkt(p, 0, 1'b0);
      model_pkt(q2);
      send_pkt(q2, 0, 1'b0);
      wait_done();
      proc_delay = 3;

      // reset after 6 bytes: only the first full word is ever written
      p = {};
      for (int i = 0; i < 6; i++) p.push_back(8'($urandom_range(255, 0)));
      exp_q.push_back({2'd0, BASE + 32'd4, p[0], p[1], p[2], p[3]});
      send_pkt(p, 0, 1'b1);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_checks();
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("abort_no_pending", exp_q.size(), 0);
      p = {};
      for (int i = 0; i < 7; i++) p.push_back(8'($urandom_range(255, 0)));
      model_pkt(p);
      send_pkt(p, 1, 1'b0);
      wait_done();

      // 12-byte packet (oversize when the length limit is enabled at 8)
      p = {};
      for (int i = 0; i < 12; i++) p.push_back(8'(8'h30 + i));
      model_pkt(p);
      send_pkt(p, 0, 1'b0);
      wait_done();

      // random packets
      for (int n = 0; n < 12; n++) begin
         p = {};
         for (int i = 0; i < $urandom_range(40, 1); i++) p.push_back(8'($urandom_range(255, 0)));
         proc_delay = $urandom_range(5, 1);
         model_pkt(p);
         send_pkt(p, 2, 1'b0);
         wait_done();
      end

      repeat (5) @(posedge clk);
      check("final_exp_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      fail("watchdog", "simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pkt_writer.md
Name: pkt_writer

Overview:
Packet ingress writer: the producer end of the packet buffer that `proc` reads.
- Accepts a byte stream with a valid/ready/last handshake.
- Packs bytes big-endian into 32-bit words and writes them through the `mem` word/width port into SRAM starting at BASE_ADDR+4.
- Writes the byte length at BASE_ADDR, then pulses `proc` start and holds off the next packet until `proc` signals ready.

Parameters:
BASE_ADDR, 0, byte address of the length word; payload starts at BASE_ADDR+4.
MAX_PKT_BYTES, 1536, oversize limit; used only with the optional feature.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
rx_valid_i  in  1  byte valid
rx_data_i  in  8  packet byte
rx_last_i  in  1  final byte of packet (qualified by valid)
rx_ready_o  out  1  byte accepted when valid&ready
mem_ce_o  out  1  memory chip enable
mem_we_o  out  1  write enable; always equals mem_ce_o
mem_addr_o  out  `ADDR_BUS  byte address, word aligned
mem_width_o  out  4  bytes written; always 4 when ce
mem_data_o  out  `DATA_BUS  write data
pkt_addr_o  out  `ADDR_BUS  constant BASE_ADDR+4 (drives proc pkt_addr_i)
proc_start_o  out  1  one-cycle start pulse to proc
proc_ready_i  in  1  proc ready_o
pkt_len_o  out  16  byte length of last completed packet
err_oversize_o  out  1  oversize flag (optional feature)

Behaviour:
- Reset (rst=0 sampled at posedge): all outputs 0 except pkt_addr_o. State goes to IDLE. Any partial packet is discarded and no writes or start follow it.
- States:
  - IDLE: rx_ready_o=1. First accepted byte -> RECV; if it also has rx_last_i, go straight to FLUSH.
  - RECV: rx_ready_o=1. Bytes shift into a 4-byte packer; byte k goes to bits [31-8*(k%4) -: 8].
    - 4th byte of a word accepted in cycle T -> write to BASE_ADDR+4+4*(k/4) issued in T+1 (ce=we=1, width=4).
    - Byte counter (16 bit) increments per accepted byte.
    - rx_last_i accepted -> FLUSH.
  - FLUSH: rx_ready_o=0.
    - Tail word pending (byte count not a multiple of 4): written this cycle, unused low bytes zero-padded.
    - Count an exact multiple of 4: the final full word's write occupies this cycle; no extra padded write.
    - -> HDR.
  - HDR: write {16'd0, len} to BASE_ADDR; pkt_len_o <= len. -> START.
  - START: proc_start_o=1 for exactly one cycle. -> WAIT.
  - WAIT: rx_ready_o=0. Waits for a 0->1 transition of sampled proc_ready_i, then -> IDLE with counter cleared.
- Latency: last byte accepted at T -> data write T+1, length write T+2, start pulse T+3.
- At most one mem write per cycle; no write conflicts occur.
- mem_ce_o=0 on all non-write cycles; address and data values then are don't-care.
- rx_valid_i with rx_ready_o=0: the byte is not consumed and the sender holds it.
- Packets of 0 bytes are impossible; every packet has at least one byte.

Optional Feature:
PKT_WRITER_LEN_CHECK_EN
- Defined:
  - Bytes beyond MAX_PKT_BYTES are still accepted (ready stays 1) but not written.
  - Length word and pkt_len_o report MAX_PKT_BYTES.
  - err_oversize_o asserts in the START cycle for one cycle.
- Undefined: no limit is applied, the counter wraps at 2^16, and err_oversize_o is tied 0.

Decomposition:
- def.vh additions: state encodings PW_IDLE..PW_WAIT, `MEM_WIDTH_WORD 4'd4, `PKT_LEN_OFF 4.
- Reuse existing `ADDR_BUS, `DATA_BUS, `TRUE, `FALSE.
- One natural sub-module: pkt_byte_packer.
  - Holds the byte index and shift register; outputs word_valid and the padded word.
  - Provides a flush input for the tail.

Test Plan:
- 14 bytes 0x00..0x0D, BASE 0 -> writes in order:
  - addr4=0x00010203, addr8=0x04050607, addr12=0x08090A0B, addr16=0x0C0D0000
  - then addr0=0x0000000E
  - start pulse 3 cycles after last byte; pkt_addr_o=4.
- Single byte 0xAB with last -> addr4=0xAB000000, addr0=0x00000001, pkt_len_o=1.
- 8 bytes 0x10..0x17 -> exactly two data writes (0x10111213, 0x14151617) plus length 8; no padded third write.
- Back-to-back packets, proc_ready_i held low 20 cycles -> rx_ready_o=0 throughout WAIT. First byte of the 2nd packet is held and accepted only after the ready rising edge, then written to addr4.
- rst=0 after 6 bytes accepted -> no further mem_ce_o and no start. Next packet writes from addr4 with correct length.
- Macro defined, MAX_PKT_BYTES=8, 12-byte packet -> two data writes, length word 8, err_oversize_o pulses with start.
